// File: rtl/lcd_text_ctrl.sv
// Character LCD controller: power-up delay, init command sequence, then redraws
// the whole display from a text snapshot latched when an update is accepted.
module lcd_text_ctrl #(
    parameter int unsigned ROWS     = 2,
    parameter int unsigned COLS     = 16,
    parameter int unsigned E_CYCLES = 25,
    parameter int unsigned CMD_WAIT = 2500,
    parameter int unsigned CLR_WAIT = 82000,
    parameter int unsigned PWR_WAIT = 750000,
    parameter int unsigned AUTO     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ROWS*COLS*8-1:0] text,
    input  logic                   update,
    output logic                   ready,
    output logic                   E,
    output logic                   RS,
    output logic                   RW,
    output logic [7:0]             DB
);

    localparam int unsigned MaxA   = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int unsigned MaxB   = (CMD_WAIT > E_CYCLES) ? CMD_WAIT : E_CYCLES;
    localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ColW   = $clog2(COLS);
    localparam int unsigned IdxW   = $clog2(ROWS * COLS * 8);

    localparam logic [CntW-1:0] ELast   = CntW'(E_CYCLES - 1);
    localparam logic [CntW-1:0] CmdLast = CntW'(CMD_WAIT - 1);
    localparam logic [CntW-1:0] ClrLast = CntW'(CLR_WAIT - 1);
    localparam logic [CntW-1:0] PwrLast = CntW'(PWR_WAIT - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);

    typedef enum logic [2:0] {StPwrup, StInit, StIdle, StAddr, StChar} state_e;
    typedef enum logic [1:0] {PhSetup, PhEhigh, PhHold, PhWait} phase_e;

    state_e                 st_q, nx_st;
    phase_e                 ph_q;
    logic [CntW-1:0]        cnt_q, wait_last;
    logic [1:0]             idx_q, nx_idx;
    logic [RowW-1:0]        row_q, nx_row;
    logic [ColW-1:0]        col_q, nx_col;
    logic                   clr_q, nx_clr, nx_rs;
    logic [7:0]             nx_db;
    logic [IdxW-1:0]        ch_lsb;
    logic [ROWS*COLS*8-1:0] snap_q;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Set-DDRAM-address command for the first column of row r.
    function automatic logic [7:0] addr_cmd(input logic [1:0] r);
        logic [6:0] base;
        case (r)
            2'd0:    base = 7'h00;
            2'd1:    base = 7'h40;
            2'd2:    base = 7'(COLS);
            default: base = 7'(64 + COLS);
        endcase
        return {1'b1, base};
    endfunction

    assign RW        = 1'b0;
    assign wait_last = clr_q ? ClrLast : CmdLast;

    // What the next write is once the current one has finished its wait.
    always_comb begin
        nx_st  = st_q;
        nx_row = row_q;
        nx_col = col_q;
        nx_idx = idx_q;
        nx_rs  = 1'b0;
        nx_db  = 8'h00;
        nx_clr = 1'b0;
        case (st_q)
            StInit: begin
                if (idx_q == 2'd3) begin
                    nx_st = StIdle;
                end else begin
                    nx_idx = idx_q + 2'd1;
                    nx_db  = init_cmd(nx_idx);
                    nx_clr = (nx_idx == 2'd2);
                end
            end
            StAddr: begin
                nx_st  = StChar;
                nx_col = '0;
                nx_rs  = 1'b1;
            end
            StChar: begin
                if (col_q == ColLast) begin
                    if (row_q == RowLast) begin
                        nx_st = StIdle;
                    end else begin
                        nx_st  = StAddr;
                        nx_row = row_q + 1'b1;
                        nx_db  = addr_cmd(2'(nx_row));
                    end
                end else begin
                    nx_col = col_q + 1'b1;
                    nx_rs  = 1'b1;
                end
            end
            default: ;
        endcase
        ch_lsb = IdxW'((32'(nx_row) * COLS + 32'(nx_col)) * 8);
        if (nx_rs) nx_db = snap_q[ch_lsb +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q   <= StPwrup;
            ph_q   <= PhSetup;
            cnt_q  <= '0;
            idx_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            clr_q  <= 1'b0;
            snap_q <= {(ROWS * COLS){8'h20}};
            ready  <= 1'b0;
            E      <= 1'b0;
            RS     <= 1'b0;
            DB     <= 8'h00;
        end else begin
            case (st_q)
                StPwrup: begin
                    if (cnt_q == PwrLast) begin
                        st_q  <= StInit;
                        idx_q <= '0;
                        DB    <= init_cmd(2'd0);
                        RS    <= 1'b0;
                        clr_q <= 1'b0;
                        ph_q  <= PhSetup;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (ready && (update || (AUTO != 0))) begin
                        snap_q <= text;
                        row_q  <= '0;
                        col_q  <= '0;
                        st_q   <= StAddr;
                        ready  <= 1'b0;
                        DB     <= addr_cmd(2'd0);
                        RS     <= 1'b0;
                        clr_q  <= 1'b0;
                        ph_q   <= PhSetup;
                    end
                end
                default: begin
                    unique case (ph_q)
                        PhSetup: begin
                            E     <= 1'b1;
                            cnt_q <= '0;
                            ph_q  <= PhEhigh;
                        end
                        PhEhigh: begin
                            if (cnt_q == ELast) begin
                                E    <= 1'b0;
                                ph_q <= PhHold;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        PhHold: begin
                            cnt_q <= '0;
                            ph_q  <= PhWait;
                        end
                        PhWait: begin
                            if (cnt_q == wait_last) begin
                                cnt_q <= '0;
                                st_q  <= nx_st;
                                row_q <= nx_row;
                                col_q <= nx_col;
                                idx_q <= nx_idx;
                                if (nx_st == StIdle) begin
                                    ready <= 1'b1;
                                end else begin
                                    DB    <= nx_db;
                                    RS    <= nx_rs;
                                    clr_q <= nx_clr;
                                    ph_q  <= PhSetup;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: small 2x8 manual and auto-refresh instances plus a 4x20 instance,
// with a bus monitor and a frame model built from the display rules.
module tb_lcd_text_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rstn  [3];
    logic       upd   [3];
    logic       e_s   [3];
    logic       rs_s  [3];
    logic       rw_s  [3];
    logic       rdy_s [3];
    logic [7:0] db_s  [3];
    logic [127:0] text0, text1;
    logic [639:0] text2;

    int checks = 0;
    int errors = 0;

    lcd_text_ctrl #(.ROWS(2), .COLS(8), .E_CYCLES(2), .CMD_WAIT(3), .CLR_WAIT(6),
                    .PWR_WAIT(10), .AUTO(0)) u_dut (
        .clk(clk), .reset(rstn[0]), .text(text0), .update(upd[0]), .ready(rdy_s[0]),
        .E(e_s[0]), .RS(rs_s[0]), .RW(rw_s[0]), .DB(db_s[0]));

    lcd_text_ctrl #(.ROWS(2), .COLS(8), .E_CYCLES(2), .CMD_WAIT(3), .CLR_WAIT(6),
                    .PWR_WAIT(10), .AUTO(1)) u_auto (
        .clk(clk), .reset(rstn[1]), .text(text1), .update(upd[1]), .ready(rdy_s[1]),
        .E(e_s[1]), .RS(rs_s[1]), .RW(rw_s[1]), .DB(db_s[1]));

    lcd_text_ctrl #(.ROWS(4), .COLS(20), .E_CYCLES(1), .CMD_WAIT(1), .CLR_WAIT(2),
                    .PWR_WAIT(3), .AUTO(0)) u_big (
        .clk(clk), .reset(rstn[2]), .text(text2), .update(upd[2]), .ready(rdy_s[2]),
        .E(e_s[2]), .RS(rs_s[2]), .RW(rw_s[2]), .DB(db_s[2]));

    // One record per completed LCD write, as seen on the bus.
    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         elen;
        int         rise_cyc;
        int         fall_cyc;
        bit         stable;
    } wr_t;
    wr_t wq[$];

    logic       e_prev  [3];
    logic       prev_rs [3];
    logic [7:0] prev_db [3];
    logic       cap_rs  [3];
    logic [7:0] cap_db  [3];
    int         elen    [3];
    int         rise_c  [3];
    bit         stab    [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn[i]) begin
                e_prev[i] <= 1'b0;
            end else begin
                if (e_s[i] && !e_prev[i]) begin
                    cap_rs[i] <= rs_s[i];
                    cap_db[i] <= db_s[i];
                    elen[i]   <= 1;
                    rise_c[i] <= cyc;
                    stab[i]   <= (rs_s[i] === prev_rs[i]) && (db_s[i] === prev_db[i]);
                end else if (e_s[i] && e_prev[i]) begin
                    elen[i] <= elen[i] + 1;
                    if (rs_s[i] !== cap_rs[i] || db_s[i] !== cap_db[i]) stab[i] <= 1'b0;
                end else if (!e_s[i] && e_prev[i]) begin
                    wq.push_back('{rs: cap_rs[i], db: cap_db[i], elen: elen[i],
                                   rise_cyc: rise_c[i], fall_cyc: cyc,
                                   stable: stab[i] && (rs_s[i] === cap_rs[i])
                                           && (db_s[i] === cap_db[i])});
                end
                e_prev[i] <= e_s[i];
            end
            prev_rs[i] <= rs_s[i];
            prev_db[i] <= db_s[i];
        end
    end

    // Reference model: expected frame as a list of {RS, DB} writes.
    logic [7:0] mtxt [80];
    logic [8:0] exp_q[$];

    function automatic logic [7:0] exp_addr(input int r, input int cols);
        case (r)
            0:       return 8'h80;
            1:       return 8'hC0;
            2:       return 8'(128 + cols);
            default: return 8'(192 + cols);
        endcase
    endfunction

    task automatic build_exp(input int rows, input int cols);
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            exp_q.push_back({1'b0, exp_addr(r, cols)});
            for (int c = 0; c < cols; c++) exp_q.push_back({1'b1, mtxt[r * cols + c]});
        end
    endtask

    task automatic rand_text(input int n);
        for (int i = 0; i < n; i++) mtxt[i] = 8'($urandom_range(32, 126));
    endtask

    task automatic wait_ready(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (rdy_s[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (e_s[0] !== 1'b0) begin errors++; $display("FAIL reset_e got %b want 0", e_s[0]); end
        checks++;
        if (rs_s[0] !== 1'b0) begin errors++; $display("FAIL reset_rs got %b want 0", rs_s[0]); end
        checks++;
        if (rw_s[0] !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", rw_s[0]); end
        checks++;
        if (db_s[0] !== 8'h00) begin errors++; $display("FAIL reset_db got %h want 00", db_s[0]); end
        checks++;
        if (rdy_s[0] !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", rdy_s[0]);
        end
    endtask

    task automatic test_powerup_init;
        logic [7:0] cmds [4];
        int gaps [3];
        int k, rdy_cyc;
        bit quiet, ok;
        cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
        gaps = '{5, 5, 8};
        wq.delete();
        @(negedge clk);
        rstn[0] = 1'b1;
        k = 0;
        quiet = 1'b1;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (e_s[0] === 1'b1) break;
            if (k < 10 && (db_s[0] !== 8'h00 || rs_s[0] !== 1'b0 || rdy_s[0] !== 1'b0))
                quiet = 1'b0;
        end
        checks++;
        if (k != 11) begin errors++; $display("FAIL pwrup_len got %0d want 11", k); end
        checks++;
        if (!quiet) begin errors++; $display("FAIL pwrup_quiet got 0 want 1"); end
        rdy_cyc = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (rdy_s[0] === 1'b1) begin
                rdy_cyc = cyc;
                break;
            end
        end
        checks++;
        if (wq.size() != 4) begin
            errors++; $display("FAIL init_count got %0d want 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wq[i].db !== cmds[i] || wq[i].rs !== 1'b0 || wq[i].elen != 2
                    || !wq[i].stable) begin
                    errors++;
                    $display("FAIL init_cmd%0d got db=%h rs=%b elen=%0d stable=%0d want db=%h rs=0 elen=2 stable=1",
                             i, wq[i].db, wq[i].rs, wq[i].elen, wq[i].stable, cmds[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq[i + 1].rise_cyc - wq[i].fall_cyc != gaps[i]) begin
                    errors++;
                    $display("FAIL init_gap%0d got %0d want %0d", i,
                             wq[i + 1].rise_cyc - wq[i].fall_cyc, gaps[i]);
                end
            end
            checks++;
            if (rdy_cyc != wq[3].fall_cyc + 4) begin
                errors++;
                $display("FAIL init_ready_cyc got %0d want %0d", rdy_cyc, wq[3].fall_cyc + 4);
            end
        end
        ok = (rdy_cyc >= 0);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_ready got 0 want 1"); end
    endtask

    task automatic test_frame;
        string s;
        int hold_len;
        bit ok;
        s = "HELLO   WORLD!!!";
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                for (int i = 0; i < 16; i++) mtxt[i] = s[i];
            end else begin
                rand_text(16);
            end
            for (int i = 0; i < 16; i++) text0[8 * i +: 8] = mtxt[i];
            build_exp(2, 8);
            wq.delete();
            @(negedge clk);
            upd[0] = 1'b1;
            @(negedge clk);
            upd[0] = 1'b0;
            text0 = {$urandom, $urandom, $urandom, $urandom};
            checks++;
            if (rdy_s[0] !== 1'b0) begin
                errors++; $display("FAIL frame%0d_busy got %b want 0", it, rdy_s[0]);
            end
            hold_len = $urandom_range(5, 60);
            @(negedge clk);
            upd[0] = 1'b1;
            repeat (hold_len) @(negedge clk);
            upd[0] = 1'b0;
            wait_ready(0, 1000, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL frame%0d_done got 0 want 1", it); end
            checks++;
            if (wq.size() != exp_q.size()) begin
                errors++;
                $display("FAIL frame%0d_count got %0d want %0d", it, wq.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    checks++;
                    if ({wq[k].rs, wq[k].db} !== exp_q[k] || wq[k].elen != 2 || !wq[k].stable) begin
                        errors++;
                        $display("FAIL frame%0d_w%0d got %h elen=%0d stable=%0d want %h elen=2 stable=1",
                                 it, k, {wq[k].rs, wq[k].db}, wq[k].elen, wq[k].stable, exp_q[k]);
                    end
                end
            end
            repeat (30) @(negedge clk);
            checks++;
            if (wq.size() != 18 || rdy_s[0] !== 1'b1) begin
                errors++;
                $display("FAIL frame%0d_no_second got writes=%0d ready=%b want writes=18 ready=1",
                         it, wq.size(), rdy_s[0]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int k;
        bit ok;
        rand_text(16);
        for (int i = 0; i < 16; i++) text0[8 * i +: 8] = mtxt[i];
        wq.delete();
        @(negedge clk);
        upd[0] = 1'b1;
        @(negedge clk);
        upd[0] = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (wq.size() >= 5 && e_s[0] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_reach got 0 want 1"); end
        checks++;
        if (db_s[0] !== mtxt[4] || rs_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_char got db=%h rs=%b want db=%h rs=1", db_s[0], rs_s[0], mtxt[4]);
        end
        #1 rstn[0] = 1'b0;
        #1;
        checks++;
        if (e_s[0] !== 1'b0) begin errors++; $display("FAIL mid_async_e got %b want 0", e_s[0]); end
        checks++;
        if (db_s[0] !== 8'h00 || rs_s[0] !== 1'b0 || rdy_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_out got db=%h rs=%b ready=%b want 00 0 0",
                     db_s[0], rs_s[0], rdy_s[0]);
        end
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (e_s[0] === 1'b1) break;
        end
        checks++;
        if (k != 11 || db_s[0] !== 8'h38 || rs_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart got k=%0d db=%h rs=%b want k=11 db=38 rs=0",
                     k, db_s[0], rs_s[0]);
        end
        wait_ready(0, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_reinit got 0 want 1"); end
    endtask

    task automatic test_auto;
        int cur, pulses, bad;
        bit ok;
        rand_text(16);
        for (int i = 0; i < 16; i++) text1[8 * i +: 8] = mtxt[i];
        build_exp(2, 8);
        @(negedge clk);
        rstn[1] = 1'b1;
        wait_ready(1, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL auto_init got 0 want 1"); end
        wq.delete();
        cur = 1;
        pulses = 0;
        bad = 0;
        for (int t = 0; t < 2000 && wq.size() < 54; t++) begin
            @(negedge clk);
            if (rdy_s[1] === 1'b1) begin
                cur++;
            end else if (cur > 0) begin
                if (cur != 1) bad++;
                pulses++;
                cur = 0;
            end
        end
        checks++;
        if (wq.size() != 54) begin
            errors++; $display("FAIL auto_count got %0d want 54", wq.size());
        end else begin
            for (int k = 0; k < 54; k++) begin
                checks++;
                if ({wq[k].rs, wq[k].db} !== exp_q[k % 18] || wq[k].elen != 2) begin
                    errors++;
                    $display("FAIL auto_w%0d got %h elen=%0d want %h elen=2",
                             k, {wq[k].rs, wq[k].db}, wq[k].elen, exp_q[k % 18]);
                end
            end
        end
        checks++;
        if (bad != 0 || pulses != 3) begin
            errors++;
            $display("FAIL auto_ready got pulses=%0d long=%0d want pulses=3 long=0", pulses, bad);
        end
        rstn[1] = 1'b0;
    endtask

    task automatic test_big;
        bit ok;
        logic [7:0] addrs [4];
        addrs = '{8'h80, 8'hC0, 8'h94, 8'hD4};
        @(negedge clk);
        rstn[2] = 1'b1;
        wait_ready(2, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL big_init got 0 want 1"); end
        rand_text(80);
        for (int i = 0; i < 80; i++) text2[8 * i +: 8] = mtxt[i];
        build_exp(4, 20);
        wq.delete();
        @(negedge clk);
        upd[2] = 1'b1;
        @(negedge clk);
        upd[2] = 1'b0;
        wait_ready(2, 2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL big_done got 0 want 1"); end
        checks++;
        if (wq.size() != 84) begin
            errors++; $display("FAIL big_count got %0d want 84", wq.size());
        end else begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (wq[r * 21].db !== addrs[r] || wq[r * 21].rs !== 1'b0) begin
                    errors++;
                    $display("FAIL big_addr%0d got %h want %h", r, wq[r * 21].db, addrs[r]);
                end
            end
            for (int k = 0; k < 84; k++) begin
                checks++;
                if ({wq[k].rs, wq[k].db} !== exp_q[k] || wq[k].elen != 1 || !wq[k].stable) begin
                    errors++;
                    $display("FAIL big_w%0d got %h elen=%0d want %h elen=1",
                             k, {wq[k].rs, wq[k].db}, wq[k].elen, exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0;
            upd[i]  = 1'b0;
        end
        text0 = {16{8'h20}};
        text1 = {16{8'h20}};
        text2 = {80{8'h20}};
        repeat (3) @(negedge clk);
        test_reset;
        test_powerup_init;
        test_frame;
        test_reset_midframe;
        test_auto;
        test_big;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
